// File: rtl/nand_io_pkg.sv
// Shared constants and helpers for the NAND input-conditioning stage.
package nand_io_pkg;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 1000;

   // Operand channel indices on raw_in / level_out.
   localparam int CH_A = 0;
   localparam int CH_B = 1;

   // Bits needed to hold values 0..n-1 (minimum 1).
   function automatic int clog2_cnt(input int n);
      int w;
      int v;
      w = 0;
      v = n - 1;
      while (v > 0) begin
         w = w + 1;
         v = v >>> 1;
      end
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/nand_debounce_channel.sv
// One input channel: synchroniser chain, debounce counter, level register
// and registered edge pulses. Also reports whether the channel is quiet
// (synchronised value agrees with the level and no count is pending).
module nand_debounce_channel
   import nand_io_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = clog2_cnt(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic quiet
);

   // Count value on which a differing sync value is finally accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync_s;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Synchroniser shift: raw enters stage 0, last stage is the usable value.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
      sync_s = sync_q[SYNC_STAGES-1];
   end

   // Debounce: accept a differing value only after it has persisted for
   // DEBOUNCE_CYCLES enabled edges; any agreement restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (en) begin
         if (sync_s == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            level_d = sync_s;
            rise_d  = sync_s;
            fall_d  = ~sync_s;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser runs independently of en; everything clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Channel status from current (pre-edge) state, combined at the top.
   always_comb begin
      level_out  = level_q;
      rise_pulse = rise_q;
      fall_pulse = fall_q;
      quiet      = (sync_s == level_q) && (cnt_q == '0);
   end

endmodule

// File: rtl/nand_input_debouncer.sv
// Conditions the raw NAND operand pads: one synchronise-and-debounce
// channel per pin plus a registered "all channels settled" flag.
module nand_input_debouncer
   import nand_io_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = clog2_cnt(DEBOUNCE_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic              settled
);

   logic [NUM_CH-1:0] quiet;
   logic              settled_q, settled_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      nand_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .raw_in     (raw_in[i]),
         .level_out  (level_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .quiet      (quiet[i])
      );
   end

   // Settled when every channel is quiet before the edge.
   always_comb begin
      settled_d = &quiet;
   end

   // Settled register; updates even with en low so it tracks sync activity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) settled_q <= 1'b0;
      else     settled_q <= settled_d;
   end

   assign settled = settled_q;

endmodule

// File: tb/tb_nand_input_debouncer.sv
module tb_nand_input_debouncer;

   localparam int NCH  = 2;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [NCH-1:0] raw_in;
   logic [NCH-1:0] level_out;
   logic [NCH-1:0] rise_pulse;
   logic [NCH-1:0] fall_pulse;
   logic           settled;

   int checks = 0;
   int errors = 0;

   nand_input_debouncer #(
      .NUM_CH          (NCH),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .settled    (settled)
   );

   always #5 clk = ~clk;

   // Reference model: raw samples delayed SYNC edges; a channel's level
   // flips once its delayed sample has disagreed for DEB enabled edges.
   logic [NCH-1:0] hist[$];
   logic [NCH-1:0] m_level, m_rise, m_fall;
   logic           m_settled;
   int             m_run[NCH];

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back('0);
      m_level   = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_settled = 1'b0;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
   endtask

   task automatic model_step();
      logic [NCH-1:0] s;
      logic           all_quiet;
      if (rst) begin
         model_reset();
      end else begin
         s = hist[0];
         all_quiet = 1'b1;
         for (int c = 0; c < NCH; c++)
            if (!(s[c] == m_level[c] && m_run[c] == 0)) all_quiet = 1'b0;
         m_rise = '0;
         m_fall = '0;
         if (en) begin
            for (int c = 0; c < NCH; c++) begin
               if (s[c] == m_level[c]) begin
                  m_run[c] = 0;
               end else if (m_run[c] + 1 == DEB) begin
                  m_level[c] = s[c];
                  if (s[c]) m_rise[c] = 1'b1;
                  else      m_fall[c] = 1'b1;
                  m_run[c] = 0;
               end else begin
                  m_run[c] = m_run[c] + 1;
               end
            end
         end
         m_settled = all_quiet;
         hist.push_back(raw_in);
         if (hist.size() > SYNC) void'(hist.pop_front());
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("level_vs_model",   32'(level_out),  32'(m_level));
      chk("rise_vs_model",    32'(rise_pulse), 32'(m_rise));
      chk("fall_vs_model",    32'(fall_pulse), 32'(m_fall));
      chk("settled_vs_model", 32'(settled),    32'(m_settled));
      chk("rise_fall_excl",   32'(rise_pulse & fall_pulse), 32'(0));
   endtask

   // One clock: model steps on the edge, DUT sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int hold;
      rst    = 1'b1;
      en     = 1'b1;
      raw_in = '0;
      model_reset();
      #1;
      chk("reset_level",   32'(level_out),  32'(0));
      chk("reset_settled", 32'(settled),    32'(0));
      chk("reset_pulses",  32'({rise_pulse, fall_pulse}), 32'(0));
      ticks(2);
      chk("reset_held_settled", 32'(settled), 32'(0));

      // Release reset with idle inputs: settled on the first edge.
      rst = 1'b0;
      tick();
      chk("idle_settled_first_edge", 32'(settled), 32'(1));
      ticks(3);
      chk("idle_level", 32'(level_out), 32'(0));

      // Clean rise on channel A: accepted on edge SYNC+DEB.
      raw_in = 2'b01;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("a_rise_level",   32'(level_out[0]),  32'(e >= SYNC + DEB));
         chk("a_rise_pulse",   32'(rise_pulse[0]), 32'(e == SYNC + DEB));
         chk("a_rise_settled", 32'(settled),       32'(!(e >= 3 && e <= SYNC + DEB)));
      end

      // Channel B glitch of 3 cycles is rejected.
      raw_in = 2'b11;
      ticks(3);
      raw_in = 2'b01;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk("b_glitch_level", 32'(level_out[1]), 32'(0));
         chk("b_glitch_pulse", 32'({rise_pulse[1], fall_pulse[1]}), 32'(0));
      end
      chk("b_glitch_settled_back", 32'(settled), 32'(1));

      // Return A to 0, then both channels together.
      raw_in = 2'b00;
      ticks(10);
      raw_in = 2'b11;
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("both_rise_level", 32'(level_out),  32'((e >= 6) ? 3 : 0));
         chk("both_rise_pulse", 32'(rise_pulse), 32'((e == 6) ? 3 : 0));
      end
      raw_in = 2'b00;
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("both_fall_level", 32'(level_out),  32'((e >= 6) ? 0 : 3));
         chk("both_fall_pulse", 32'(fall_pulse), 32'((e == 6) ? 3 : 0));
      end
      ticks(3);

      // Enable freeze after two counted cycles.
      raw_in = 2'b01;
      ticks(SYNC + 2);
      en = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk("en_hold_level", 32'(level_out[0]), 32'(0));
         chk("en_hold_pulse", 32'(rise_pulse),   32'(0));
      end
      en = 1'b1;
      tick();
      chk("en_resume_1", 32'(level_out[0]), 32'(0));
      tick();
      chk("en_resume_2",       32'(level_out[0]),  32'(1));
      chk("en_resume_2_pulse", 32'(rise_pulse[0]), 32'(1));

      // Async reset mid-count with a nonzero level present.
      raw_in = 2'b10;
      ticks(10);
      chk("pre_reset_level", 32'(level_out), 32'(2));
      raw_in = 2'b11;
      ticks(SYNC + 3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_level",   32'(level_out), 32'(0));
      chk("async_rst_settled", 32'(settled),   32'(0));
      chk("async_rst_pulses",  32'({rise_pulse, fall_pulse}), 32'(0));
      @(negedge clk);
      tick();
      tick();
      rst    = 1'b0;
      raw_in = 2'b01;
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("post_rst_level", 32'(level_out[0]),  32'(e >= SYNC + DEB));
         chk("post_rst_pulse", 32'(rise_pulse[0]), 32'(e == SYNC + DEB));
      end

      // Randomised holds with occasional enable drops.
      for (int k = 0; k < 60; k++) begin
         raw_in = NCH'($urandom_range(0, 3));
         hold   = $urandom_range(1, 8);
         for (int j = 0; j < hold; j++) begin
            en = ($urandom_range(0, 7) != 0);
            tick();
         end
      end
      en = 1'b1;
      ticks(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
